// File: rtl/icache_direct_mapped_if.sv
// Fetch-side request/response and line-refill bus of the direct-mapped instruction cache.
interface icache_direct_mapped_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic                  invalidate;
    logic [DATA_WIDTH-1:0] cpu_data;
    logic                  cpu_valid;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rvalid;

    // Cache side: answers fetch requests and initiates refills.
    modport master (
        input  cpu_req, cpu_addr, invalidate, mem_ready, mem_rdata, mem_rvalid,
        output cpu_data, cpu_valid, mem_req, mem_addr
    );

    // Environment side: fetch stage plus instruction memory.
    modport slave (
        output cpu_req, cpu_addr, invalidate, mem_ready, mem_rdata, mem_rvalid,
        input  cpu_data, cpu_valid, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: single-cycle hits, whole-line refill on a miss.
module icache_direct_mapped #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           LINE_WORDS = 4,
    parameter int unsigned           NUM_LINES  = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   reset,
    icache_direct_mapped_if.master bus
);
    localparam int unsigned      OFF_W     = $clog2(LINE_WORDS);
    localparam int unsigned      IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned      LOW_W     = OFF_W + 2;
    localparam int unsigned      TAG_W     = DATA_WIDTH - IDX_W - LOW_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t                state;
    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tags [NUM_LINES];
    logic [DATA_WIDTH-1:0] data [NUM_LINES][LINE_WORDS];

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [OFF_W-1:0]      req_off;
    logic [OFF_W-1:0]      beat;

    logic [DATA_WIDTH-1:0] cpu_data_q;
    logic                  cpu_valid_q;
    logic                  mem_req_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;

    logic [OFF_W-1:0]      lk_off;
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic                  fill_beat;
    logic                  fill_last;
    logic                  unused_addr_bits;

    // Lookup on the live PC; an invalidate in the same cycle forces a miss.
    assign lk_off           = bus.cpu_addr[LOW_W-1:2];
    assign lk_idx           = bus.cpu_addr[LOW_W+IDX_W-1:LOW_W];
    assign lk_tag           = bus.cpu_addr[DATA_WIDTH-1:LOW_W+IDX_W];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];
    assign lk_hit           = valid[lk_idx] && (tags[lk_idx] == lk_tag) && !bus.invalidate;

    assign fill_beat = (state == FILL) && bus.mem_rvalid;
    assign fill_last = fill_beat && (beat == LAST_BEAT);

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            cpu_data_q  <= NOP_WORD;
            cpu_valid_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            beat        <= '0;
        end else begin
            cpu_valid_q <= 1'b0;

            // Invalidate beats a line being validated in the same cycle.
            if (bus.invalidate) begin
                valid <= '0;
            end else if (fill_last) begin
                valid[req_idx] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        if (lk_hit) begin
                            cpu_data_q  <= data[lk_idx][lk_off];
                            cpu_valid_q <= 1'b1;
                        end else begin
                            state      <= REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {lk_tag, lk_idx, LOW_W'(0)};
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        beat      <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_rvalid) begin
                        beat <= beat + OFF_W'(1);
                        if (beat == LAST_BEAT) begin
                            // Earlier words are already in the array; the last one is bypassed.
                            cpu_data_q  <= (req_off == LAST_BEAT) ? bus.mem_rdata
                                                                  : data[req_idx][req_off];
                            cpu_valid_q <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request latch, tag and data arrays; no reset needed since valid gates every use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((state == IDLE) && bus.cpu_req) begin
                req_tag <= lk_tag;
                req_idx <= lk_idx;
                req_off <= lk_off;
            end
            if (fill_beat) begin
                data[req_idx][beat] <= bus.mem_rdata;
            end
            if (fill_last) begin
                tags[req_idx] <= req_tag;
            end
        end
    end

    assign bus.cpu_data  = cpu_data_q;
    assign bus.cpu_valid = cpu_valid_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
endmodule
